div_frac: RTL and testbench
===========================

Name: div_frac

Overview:
- Parametrised sequential fractional divider; successor to the 16-bit positive-only division basic op.
- Computes out = a/b in Q(WIDTH-1) format, with optional signed mode and a configurable number of resolved quotient bits.
- Sign-aware saturation; reports division errors through a done pulse instead of stalling.
- Contains its own subtractor and counter, so it has no shared adder/subtractor ports.
- Used by the LPC/Levinson and gain FSMs wherever 16-bit div_s-style division is needed.

Parameters:
- WIDTH, 16: operand, quotient and remainder width.
- QBITS, WIDTH-1: quotient bits resolved, one per cycle. Legal range 1..WIDTH-1. The quotient is left-justified in Q(WIDTH-1) and its low WIDTH-1-QBITS bits are zero.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only when accept is possible.
- signed_mode  in  1  1 = two's-complement operands; 0 = non-negative only.
- a  in  WIDTH  numerator.
- b  in  WIDTH  denominator.
- out  out  WIDTH  quotient, registered.
- rem  out  WIDTH  final partial-remainder magnitude, registered.
- done  out  1  one-cycle result-valid pulse.
- busy  out  1  high from accept until the cycle before done.
- div_err  out  1  qualifies done: the request was illegal.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - out, rem, done, busy, div_err, iteration counter and internal registers all become 0.
  - Reset mid-operation abandons the operation; no done is issued.
- States: IDLE, CHECK, ITER, FIX, DONE.
- Accept: start=1 in IDLE or DONE.
  - On the accepting edge, capture a, b and signed_mode, then go to CHECK.
  - start in CHECK, ITER or FIX is ignored, and the captured operands are unaffected.
  - busy=1 in CHECK, ITER and FIX; otherwise busy=0.
- CHECK, first matching rule wins:
  - mag(x) = x in unsigned mode; |x| as a WIDTH-bit unsigned value in signed mode (|MIN| = 2^(WIDTH-1)).
  - neg = signed_mode & (a[MSB] ^ b[MSB]).
  1. b==0, or signed_mode=0 with a[MSB]=1 or b[MSB]=1: div_err=1, out = MAX (0x7FFF at WIDTH 16), rem=0, go to DONE.
  2. mag(a) > mag(b): div_err=1, out = MIN if neg else MAX, rem=0, go to DONE.
  3. a==0: out=0, rem=0, go to DONE.
  4. mag(a)==mag(b): out = MIN if neg else MAX, rem=0, go to DONE.
  5. Otherwise: num = mag(a), den = mag(b), quotient=0, counter=0, go to ITER.
- ITER (restoring division, one bit per cycle):
  - num = num<<1, using a WIDTH+1-bit internal register.
  - If num >= den: num = num - den and shift in quotient bit 1; else shift in 0.
  - Counter increments each cycle; after QBITS iterations go to FIX.
- FIX:
  - q = quotient << (WIDTH-1-QBITS).
  - out = neg ? -q : q.
  - rem = num[WIDTH-1:0], always less than den.
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle; div_err is valid in the same cycle.
  - Next state is IDLE, or CHECK if start=1.
  - div_err clears when leaving DONE.
  - out and rem hold until the next CHECK or FIX writes them.
- Latency, counted from the accepting edge (edge 0):
  - Early exits (rules 1-4): done is high in the cycle after edge 1, i.e. 2 cycles.
  - Normal path: done after QBITS+3 cycles; 18 at default parameters.
  - Back-to-back: accepting in DONE gives one request per QBITS+3 cycles.
- Result range: the result is never -0. Negative quotients stay above MIN except in rule 4.

Test Plan:
- Default parameters, unsigned, a=0x2000, b=0x4000 -> out=0x4000, rem=0, div_err=0, done exactly 18 cycles after accept, busy high for 17 cycles.
- Unsigned, a=0x0001, b=0x0003 -> out=0x2AAA, rem=0x0002. With QBITS=8 and the same operands -> out=0x2A80, done at 11 cycles.
- Signed checks:
  - a=0xE000, b=0x4000 -> out=0xC000.
  - a=0xC000, b=0x4000 -> out=0x8000 at 2 cycles.
  - a=0x2000, b=0xC000 -> out=0xC000.
  - a=0xC000, b=0x2000 -> div_err=1, out=0x8000.
- Error cases, each at 2 cycles:
  - b=0 -> div_err=1, out=0x7FFF.
  - Unsigned a=0x5000, b=0x4000 -> div_err=1, out=0x7FFF.
  - Unsigned a=0x8000 -> div_err=1.
  - A following legal start gives div_err=0.
- Shortcuts: a=0, b=0x1234 -> out=0 at 2 cycles; a=b=0x1234 -> out=0x7FFF at 2 cycles.
- Control handling:
  - Start pulses during ITER with new operands -> ignored; the first result is unchanged.
  - Start held high through DONE -> a second operation is accepted with no idle cycle.
  - reset=0 mid-ITER -> all outputs 0 immediately; no done; the next start completes correctly.

Source files
------------

// File: rtl/div_frac.sv
// Sequential fractional divider: out = a/b in Q(WIDTH-1), one restoring-division
// quotient bit per cycle, with sign-aware saturation and error reporting on done.
module div_frac #(
  parameter int WIDTH = 16,
  parameter int QBITS = WIDTH - 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             done,
  output logic             busy,
  output logic             div_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int SH = WIDTH - 1 - QBITS;
  localparam logic [WIDTH-1:0] MAX_Q = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_Q = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_p0, b_p0;
  logic              sm_p0;
  logic              neg_p1;
  logic [WIDTH:0]    num_p1;
  logic [WIDTH-1:0]  den_p1;
  logic [WIDTH-1:0]  quo_p1;
  logic [CW-1:0]     cnt_p1;

  logic [WIDTH-1:0]  mag_a, mag_b;
  logic              neg, illegal, ge;
  logic [WIDTH:0]    num_sh, num_nx;

  // Magnitude as an unsigned value; |MIN| maps naturally to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sm);
    logic signed [WIDTH-1:0] xs;
    xs = signed'(x);
    return (sm && x[WIDTH-1]) ? WIDTH'(-xs) : x;
  endfunction

  function automatic logic [WIDTH-1:0] sat_q(input logic n);
    return n ? MIN_Q : MAX_Q;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] q, input logic n);
    logic signed [WIDTH-1:0] qs;
    qs = signed'(q);
    return n ? WIDTH'(-qs) : q;
  endfunction

  always_comb begin
    mag_a   = mag(a_p0, sm_p0);
    mag_b   = mag(b_p0, sm_p0);
    neg     = sm_p0 & (a_p0[WIDTH-1] ^ b_p0[WIDTH-1]);
    illegal = (b_p0 == '0) | (~sm_p0 & (a_p0[WIDTH-1] | b_p0[WIDTH-1]));
    num_sh  = num_p1 << 1;
    ge      = num_sh >= {1'b0, den_p1};
    num_nx  = ge ? (num_sh - {1'b0, den_p1}) : num_sh;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      out     <= '0;
      rem     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      div_err <= 1'b0;
      a_p0    <= '0;
      b_p0    <= '0;
      sm_p0   <= 1'b0;
      neg_p1  <= 1'b0;
      num_p1  <= '0;
      den_p1  <= '0;
      quo_p1  <= '0;
      cnt_p1  <= '0;
    end else begin
      case (state)
        // p0: operand capture
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_p0  <= a;
            b_p0  <= b;
            sm_p0 <= signed_mode;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        // p1: classification and early exits
        CHECK: begin
          neg_p1 <= neg;
          if (illegal) begin
            div_err <= 1'b1;
            out     <= MAX_Q;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (mag_a > mag_b) begin
            div_err <= 1'b1;
            out     <= sat_q(neg);
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (a_p0 == '0) begin
            out   <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (mag_a == mag_b) begin
            out   <= sat_q(neg);
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            num_p1 <= {1'b0, mag_a};
            den_p1 <= mag_b;
            quo_p1 <= '0;
            cnt_p1 <= '0;
            state  <= ITER;
          end
        end
        // p1: one restoring-division step per cycle
        ITER: begin
          num_p1 <= num_nx;
          quo_p1 <= {quo_p1[WIDTH-2:0], ge};
          cnt_p1 <= cnt_p1 + CW'(1);
          if (cnt_p1 == CW'(QBITS - 1)) state <= FIX;
        end
        // p2: left-justify, apply sign, publish
        FIX: begin
          out   <= apply_sign(quo_p1 << SH, neg_p1);
          rem   <= num_p1[WIDTH-1:0];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          div_err <= 1'b0;
          if (start) begin
            a_p0  <= a;
            b_p0  <= b;
            sm_p0 <= signed_mode;
            busy  <= 1'b1;
            state <= CHECK;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_frac.sv
// Bench for div_frac: directed vector table, randomized ops against an arithmetic
// reference model, and hand-written control sequences (ignored starts, chaining, reset).
module tb_div_frac;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start0 = 1'b0, start8 = 1'b0;
  logic        sm_in = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic [15:0] out0, rem0, out8, rem8;
  logic        done0, busy0, err0, done8, busy8, err8;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  div_frac #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start0), .signed_mode(sm_in),
    .a(a_in), .b(b_in), .out(out0), .rem(rem0),
    .done(done0), .busy(busy0), .div_err(err0)
  );

  div_frac #(.WIDTH(16), .QBITS(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_mode(sm_in),
    .a(a_in), .b(b_in), .out(out8), .rem(rem8),
    .done(done8), .busy(busy8), .div_err(err8)
  );

  typedef struct {
    logic [15:0] a, b;
    logic        sm;
    bit          sel;
    logic [15:0] out, rem;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: exact fraction a/b truncated to qb bits, then left-justified.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                                input int qb, output logic [15:0] o, output logic [15:0] r,
                                output logic e, output int lat);
    longint ma, mb, q;
    bit     ng;
    ma  = (sm && av[15]) ? 65536 - longint'(av) : longint'(av);
    mb  = (sm && bv[15]) ? 65536 - longint'(bv) : longint'(bv);
    ng  = sm && (av[15] != bv[15]);
    o   = 16'h0;
    r   = 16'h0;
    e   = 1'b0;
    lat = 2;
    if (bv == 16'h0 || (!sm && (av[15] || bv[15]))) begin
      e = 1'b1;
      o = 16'h7FFF;
    end else if (ma > mb) begin
      e = 1'b1;
      o = ng ? 16'h8000 : 16'h7FFF;
    end else if (av == 16'h0) begin
      o = 16'h0;
    end else if (ma == mb) begin
      o = ng ? 16'h8000 : 16'h7FFF;
    end else begin
      q   = (ma << qb) / mb;
      r   = 16'((ma << qb) % mb);
      q   = q << (15 - qb);
      o   = ng ? 16'(-q) : 16'(q);
      lat = qb + 3;
    end
  endfunction

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                        input bit sel, output logic [15:0] o, output logic [15:0] r,
                        output logic e, output int lat, output int busyc);
    int acc;
    bit seen;
    @(negedge clock);
    a_in = av; b_in = bv; sm_in = sm;
    if (sel) start8 = 1'b1; else start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; start8 = 1'b0;
    acc = cyc; busyc = 0; seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (sel ? done8 : done0) seen = 1'b1;
      else begin
        if (sel ? busy8 : busy0) busyc++;
        @(posedge clock); #1;
      end
    end
    lat = seen ? (cyc - acc + 1) : -1;
    o = sel ? out8 : out0;
    r = sel ? rem8 : rem0;
    e = sel ? err8 : err0;
    @(posedge clock); #1;
    chk("done_one_cycle", 32'(sel ? done8 : done0), 32'd0);
  endtask

  task automatic wait_done(input int acc, output int lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (done0) seen = 1'b1;
      else begin @(posedge clock); #1; end
    end
    lat = seen ? (cyc - acc + 1) : -1;
  endtask

  initial begin
    logic [15:0] o, r, eo, er;
    logic        e, ee;
    int          lat, elat, bc, acc, acc2, dcyc, ma, mb, ndone;
    logic [15:0] av, bv;
    logic        sm;

    vecs[0]  = '{16'h2000, 16'h4000, 1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0, 18};
    vecs[1]  = '{16'h0001, 16'h0003, 1'b0, 1'b0, 16'h2AAA, 16'h0002, 1'b0, 18};
    vecs[2]  = '{16'h0001, 16'h0003, 1'b0, 1'b1, 16'h2A80, 16'h0001, 1'b0, 11};
    vecs[3]  = '{16'hE000, 16'h4000, 1'b1, 1'b0, 16'hC000, 16'h0000, 1'b0, 18};
    vecs[4]  = '{16'hC000, 16'h4000, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 2};
    vecs[5]  = '{16'h2000, 16'hC000, 1'b1, 1'b0, 16'hC000, 16'h0000, 1'b0, 18};
    vecs[6]  = '{16'hC000, 16'h2000, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 2};
    vecs[7]  = '{16'h1234, 16'h0000, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 2};
    vecs[8]  = '{16'h5000, 16'h4000, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 2};
    vecs[9]  = '{16'h8000, 16'h4000, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 2};
    vecs[10] = '{16'h1000, 16'h4000, 1'b0, 1'b0, 16'h2000, 16'h0000, 1'b0, 18};
    vecs[11] = '{16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2};
    vecs[12] = '{16'h1234, 16'h1234, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 2};
    vecs[13] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 2};
    vecs[14] = '{16'h0001, 16'h8000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 18};

    #12;
    chk("rst_out", 32'(out0), 32'h0);
    chk("rst_rem", 32'(rem0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_err", 32'(err0), 32'h0);
    @(negedge clock); reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].sel, o, r, e, lat, bc);
      chk($sformatf("vec%0d_out", i), 32'(o), 32'(vecs[i].out));
      chk($sformatf("vec%0d_rem", i), 32'(r), 32'(vecs[i].rem));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy", i), 32'(bc), 32'(vecs[i].lat - 1));
    end

    for (int i = 0; i < 60; i++) begin
      bit sel;
      sel = (i >= 45);
      sm  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        av = 16'($urandom);
        bv = 16'($urandom);
      end else begin
        mb = sm ? int'($urandom_range(1, 32768)) : int'($urandom_range(1, 32767));
        ma = int'($urandom_range(0, 32'(mb - 1)));
        av = 16'(ma);
        bv = 16'(mb);
        if (sm && (mb == 32768 || $urandom_range(0, 1) == 1)) bv = 16'(-mb);
        if (sm && $urandom_range(0, 1) == 1) av = 16'(-ma);
      end
      model(av, bv, sm, sel ? 8 : 15, eo, er, ee, elat);
      run_op(av, bv, sm, sel, o, r, e, lat, bc);
      chk($sformatf("rnd%0d_out a=%h b=%h s=%0d", i, av, bv, sm), 32'(o), 32'(eo));
      chk($sformatf("rnd%0d_rem", i), 32'(r), 32'(er));
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(ee));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
    end

    // Start pulses with new operands while iterating must be ignored.
    @(negedge clock);
    a_in = 16'h0001; b_in = 16'h0003; sm_in = 1'b0; start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; acc = cyc;
    repeat (3) begin @(posedge clock); #1; end
    a_in = 16'h7000; b_in = 16'h1000; sm_in = 1'b1; start0 = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    start0 = 1'b0;
    wait_done(acc, lat);
    chk("ign_lat", 32'(lat), 32'd18);
    chk("ign_out", 32'(out0), 32'h2AAA);
    chk("ign_rem", 32'(rem0), 32'h0002);
    chk("ign_err", 32'(err0), 32'h0);
    @(posedge clock); #1;

    // Start held high through DONE chains the next request with no idle cycle.
    @(negedge clock);
    a_in = 16'h2000; b_in = 16'h4000; sm_in = 1'b0; start0 = 1'b1;
    @(posedge clock); #1;
    acc = cyc;
    wait_done(acc, lat);
    dcyc = cyc;
    chk("chain1_lat", 32'(lat), 32'd18);
    chk("chain1_out", 32'(out0), 32'h4000);
    a_in = 16'h0001; b_in = 16'h0003;
    @(posedge clock); #1;
    acc2 = cyc; start0 = 1'b0;
    chk("chain_busy", 32'(busy0), 32'd1);
    chk("chain_gap", 32'(acc2 - dcyc), 32'd1);
    wait_done(acc2, lat);
    chk("chain2_lat", 32'(lat), 32'd18);
    chk("chain2_out", 32'(out0), 32'h2AAA);
    chk("chain2_rem", 32'(rem0), 32'h0002);
    @(posedge clock); #1;

    // Asynchronous reset mid-iteration clears outputs at once and drops the op.
    @(negedge clock);
    a_in = 16'h0001; b_in = 16'h0003; sm_in = 1'b0; start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    chk("mrst_out", 32'(out0), 32'h0);
    chk("mrst_rem", 32'(rem0), 32'h0);
    chk("mrst_done", 32'(done0), 32'h0);
    chk("mrst_busy", 32'(busy0), 32'h0);
    chk("mrst_err", 32'(err0), 32'h0);
    @(negedge clock); reset = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done0) ndone++;
    end
    chk("mrst_no_done", 32'(ndone), 32'd0);
    run_op(16'h2000, 16'h4000, 1'b0, 1'b0, o, r, e, lat, bc);
    chk("mrst_after_out", 32'(o), 32'h4000);
    chk("mrst_after_lat", 32'(lat), 32'd18);
    chk("mrst_after_err", 32'(e), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
